// File: rtl/conv_encoder.sv
// Rate-1/2, K=3 convolutional encoder with zero-tail termination.
// Information bits arrive serially; each terminated block of coded pairs
// is packed MSB-first into one parallel word and flagged with a one-cycle
// strobe for the downstream interleaver.
module conv_encoder #(
    parameter int         INFO_BITS = 12,
    parameter logic [2:0] G0        = 3'b111,
    parameter logic [2:0] G1        = 3'b101
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         din,
    output logic                         ready,
    output logic                         en_out,
    output logic [2*(INFO_BITS+2)-1:0]   data_out
);

    // Coded block width: two code bits per information bit plus two tail bits.
    localparam int BLK   = 2 * (INFO_BITS + 2);
    // Number of coded pairs per block (information pairs plus tail pairs).
    localparam int NPAIR = INFO_BITS + 2;
    // Pair counter must reach INFO_BITS+1 during the second flush cycle.
    localparam int PW    = $clog2(NPAIR + 1);

    localparam logic [PW-1:0] LAST_INFO = PW'(INFO_BITS - 1);
    localparam logic [PW-1:0] CNT_ONE   = PW'(1);

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        FLUSH1 = 2'd1,
        FLUSH2 = 2'd2
    } state_t;

    state_t           state_q;
    logic [PW-1:0]    cnt_q;      // index of the pair being written
    logic [1:0]       sreg_q;     // {s1, s0}, s1 is the most recent bit
    logic [BLK-1:0]   buf_q;      // partial block under construction
    logic [BLK-1:0]   data_q;     // last completed codeword
    logic             en_out_q;
    logic             ready_q;

    logic             bit_d;      // bit entering the trellis this cycle
    logic [2:0]       win_d;      // encoder window {b, s1, s0}
    logic             c0_d;
    logic             c1_d;
    logic [BLK-1:0]   buf_d;      // build buffer with the current pair inserted

    // Modulo-2 inner product of the encoder window with a generator.
    function automatic logic parity_tap(input logic [2:0] w, input logic [2:0] g);
        return ^(w & g);
    endfunction

    // Tail cycles feed zeros into the trellis; loading feeds the input bit.
    always_comb begin
        bit_d = 1'b0;
        if (state_q == LOAD) begin
            bit_d = din;
        end
    end

    assign win_d = {bit_d, sreg_q};
    assign c0_d  = parity_tap(win_d, G0);
    assign c1_d  = parity_tap(win_d, G1);

    // Drop the current coded pair into its MSB-first slot of the block.
    always_comb begin
        buf_d = buf_q;
        for (int p = 0; p < NPAIR; p++) begin
            if (cnt_q == PW'(p)) begin
                buf_d[BLK-1-2*p] = c0_d;
                buf_d[BLK-2-2*p] = c1_d;
            end
        end
    end

    // Block sequencer: load info bits, run two tail cycles, publish the word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= LOAD;
            cnt_q    <= '0;
            sreg_q   <= '0;
            buf_q    <= '0;
            data_q   <= '0;
            en_out_q <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            en_out_q <= 1'b0;
            case (state_q)
                LOAD: begin
                    if (en && ready_q) begin
                        buf_q  <= buf_d;
                        sreg_q <= {din, sreg_q[1]};
                        cnt_q  <= cnt_q + CNT_ONE;
                        if (cnt_q == LAST_INFO) begin
                            state_q <= FLUSH1;
                            ready_q <= 1'b0;
                        end
                    end
                end
                FLUSH1: begin
                    buf_q   <= buf_d;
                    sreg_q  <= {1'b0, sreg_q[1]};
                    cnt_q   <= cnt_q + CNT_ONE;
                    state_q <= FLUSH2;
                end
                FLUSH2: begin
                    // The final tail pair goes straight into the output word.
                    buf_q    <= buf_d;
                    data_q   <= buf_d;
                    en_out_q <= 1'b1;
                    sreg_q   <= '0;
                    cnt_q    <= '0;
                    state_q  <= LOAD;
                    ready_q  <= 1'b1;
                end
                default: begin
                    sreg_q  <= '0;
                    cnt_q   <= '0;
                    state_q <= LOAD;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ready    = ready_q;
    assign en_out   = en_out_q;
    assign data_out = data_q;

endmodule
